mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 104 ++++++++++
 tb/tb_mult_div_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO multiply/divide unit with fixed-latency multiply and 32-cycle shift-subtract divide.
// MTHI/MTLO write HI/LO directly; reserved op codes are ignored.
module mult_div_unit #(
   parameter int MUL_LATENCY = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
   localparam logic [5:0] MUL_LOAD = 6'(MUL_LATENCY - 1);
   state_t      r_state, w_next;
   logic [5:0]  r_cnt;
   logic [31:0] r_hi, r_lo, r_rem, r_quo, r_dvsr, r_a;
   logic [63:0] r_prod;
   logic        r_done, r_neg_q, r_neg_r, r_dz;
   logic        w_accept, w_finish, w_is_mul, w_is_div, w_signed;
   logic [63:0] w_ma, w_mb, w_prod;
   logic [32:0] w_shift, w_diff;
   logic [31:0] w_mag_a, w_mag_b, w_rem_n, w_quo_n, w_q, w_r;

   assign busy     = r_state != S_IDLE;
   assign done     = r_done;
   assign hi       = r_hi;
   assign lo       = r_lo;
   assign w_accept = start && !busy;
   assign w_is_mul = op == 3'd0 || op == 3'd1;
   assign w_is_div = op == 3'd2 || op == 3'd3;
   assign w_signed = op == 3'd0 || op == 3'd2;
   assign w_finish = busy && r_cnt == 6'd0;
   // Low 64 bits of the product of sign/zero-extended operands give the signed/unsigned result
   assign w_ma     = {{32{w_signed & operand_a[31]}}, operand_a};
   assign w_mb     = {{32{w_signed & operand_b[31]}}, operand_b};
   assign w_prod   = w_ma * w_mb;
   assign w_mag_a  = (w_signed && operand_a[31]) ? -operand_a : operand_a;
   assign w_mag_b  = (w_signed && operand_b[31]) ? -operand_b : operand_b;
   // One restoring step: the dividend shifts out of r_quo as quotient bits shift in
   assign w_shift  = {r_rem, r_quo[31]};
   assign w_diff   = w_shift - {1'b0, r_dvsr};
   assign w_rem_n  = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
   assign w_quo_n  = {r_quo[30:0], ~w_diff[32]};
   assign w_q      = r_neg_q ? -w_quo_n : w_quo_n;
   assign w_r      = r_neg_r ? -w_rem_n : w_rem_n;

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (r_state == S_IDLE && w_accept) w_next = w_is_mul ? S_MUL : w_is_div ? S_DIV : S_IDLE;
      else if (w_finish)                 w_next = S_IDLE;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_dvsr  <= '0;
         r_a     <= '0;
         r_prod  <= '0;
         r_done  <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
      end else begin
         r_done <= w_finish || (w_accept && (op == 3'd4 || op == 3'd5));
         if (w_accept && (w_is_mul || w_is_div)) begin
            r_cnt   <= w_is_mul ? MUL_LOAD : 6'd31;
            r_prod  <= w_prod;
            r_rem   <= '0;
            r_quo   <= w_mag_a;
            r_dvsr  <= w_mag_b;
            r_neg_q <= w_signed & (operand_a[31] ^ operand_b[31]);
            r_neg_r <= w_signed & operand_a[31];
            r_dz    <= operand_b == 32'd0;
            r_a     <= operand_a;
         end else if (busy && r_cnt != 6'd0) begin
            r_cnt <= r_cnt - 6'd1;
         end
         if (r_state == S_DIV) begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
         end
         if (w_accept && op == 3'd4) r_hi <= operand_a;
         if (w_accept && op == 3'd5) r_lo <= operand_a;
         if (w_finish) begin
            r_hi <= r_state == S_MUL ? r_prod[63:32] : r_dz ? r_a : w_r;
            r_lo <= r_state == S_MUL ? r_prod[31:0] : r_dz ? 32'hFFFF_FFFF : w_q;
         end
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: random and directed stimulus against an arithmetic reference model,
// with a queue-based scoreboard checked whenever done pulses.
module tb_mult_div_unit;
   localparam int ML = 4;
   logic        clock, reset, start, busy, done;
   logic [2:0]  op;
   logic [31:0] operand_a, operand_b, hi, lo;

   typedef struct {logic [63:0] v; int t; int lat;} exp_t;
   exp_t        q[$];
   logic [63:0] m_state, last;
   int          total, bad, cyc, bcnt;
   bit          armed;

   mult_div_unit #(.MUL_LATENCY(ML)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string n, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h at cycle %0d", n, got, want, cyc);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] cur);
      longint sa, sb, qs, rs;
      logic [63:0] ua, ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (o)
         3'd0: return sa * sb;
         3'd1: return ua * ub;
         3'd2, 3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (o == 3'd3) return {a % b, a / b};
            qs = sa / sb;
            rs = sa % sb;
            return {rs[31:0], qs[31:0]};
         end
         3'd4: return {a, cur[31:0]};
         default: return {cur[63:32], a};
      endcase
   endfunction

   // Monitor: hi/lo must hold between completions; each done pops one expectation
   always @(posedge clock) begin
      #1;
      if (reset) begin
         last  = '0;
         bcnt  = 0;
         armed = 1'b1;
      end else if (armed) begin
         if (busy) bcnt++;
         if (done) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done got hi=%h lo=%h want no done", hi, lo);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("hilo", {hi, lo}, e.v);
               check("latency", 64'(cyc - e.t), 64'(e.lat));
               check("busy_cycles", 64'(bcnt), 64'(e.lat));
               last = e.v;
            end
            bcnt = 0;
         end else begin
            check("hold", {hi, lo}, last);
         end
      end
   end

   // Called just after a negedge; returns just after a later negedge
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      logic [63:0] nv;
      while (busy && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL busy_timeout got busy=1 want 0 within 100 cycles");
      end
      start = 1'b1;
      op = o;
      operand_a = a;
      operand_b = b;
      if (!busy && o <= 3'd5) begin
         nv = model(o, a, b, m_state);
         q.push_back('{v: nv, t: cyc + 1, lat: o <= 3'd1 ? ML : o <= 3'd3 ? 32 : 0});
         m_state = nv;
      end
      @(negedge clock);
      start = 1'b0;
      operand_a = $urandom;
      operand_b = $urandom;
      op = 3'($urandom);
   endtask

   task automatic poke();
      if (busy) begin
         start = 1'b1;
         op = 3'($urandom_range(0, 5));
         operand_a = $urandom;
         operand_b = $urandom;
         @(negedge clock);
         start = 1'b0;
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;
      logic [2:0] o;
      total = 0; bad = 0; cyc = 0; bcnt = 0; armed = 1'b0;
      m_state = '0; last = '0;
      reset = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0;
      repeat (3) @(negedge clock);
      check("reset_hilo", {hi, lo}, 64'd0);
      check("reset_busy_done", {62'd0, busy, done}, 64'd0);
      reset = 1'b0;
      @(negedge clock);
      issue(3'd0, 32'hFFFF_FFFE, 32'd3);
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      poke();
      poke();
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      issue(3'd3, 32'd7, 32'd0);
      issue(3'd6, 32'h1111_1111, 32'd5);
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(3'd5, 32'h1234_5678, 32'd0);
      issue(3'd7, 32'h2222_2222, 32'd5);
      issue(3'd4, 32'hCAFE_F00D, 32'd0);
      issue(3'd2, 32'hFFFF_0000, 32'd3);
      repeat (9) @(negedge clock);
      reset = 1'b1;
      q.delete();
      m_state = '0;
      @(negedge clock);
      reset = 1'b0;
      check("abort_busy_done", {62'd0, busy, done}, 64'd0);
      check("abort_hilo", {hi, lo}, 64'd0);
      reset = 1'b1;
      start = 1'b1;
      op = 3'd4;
      operand_a = 32'hDEAD_BEEF;
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clock);
      check("start_in_reset", {hi, 30'd0, busy, done}, 64'd0);
      issue(3'd3, 32'd100, 32'd7);
      for (int i = 0; i < 60; i++) begin
         n = $urandom_range(0, 15);
         o = n < 14 ? 3'(n % 6) : 3'(n - 8);
         repeat ($urandom_range(0, 2)) @(negedge clock);
         if ($urandom_range(0, 3) == 0) poke();
         issue(o, pick(), pick());
      end
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("queue_drained", 64'(q.size()), 64'd0);
      repeat (3) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
